poc_decoder_multi: RTL and testbench
====================================

Name: poc_decoder_multi

Overview:
- Parametrised H.264 picture-order-count engine for all three pic_order_cnt_type modes (0/1/2).
- Signed top and bottom field POC outputs; internal offset_for_ref_frame table; iterative type-1 datapath (divider, multiplier, accumulator).
- Sits between the slice-header parser and the DPB/output-ordering logic, driven by a start/done handshake once per picture.

Parameters:
FRAME_NUM_W, 16, width of frame_num (log2_max_frame_num ≤ FRAME_NUM_W)
LSB_W, 16, width of pic_order_cnt_lsb
POC_W, 32, signed POC/offset/accumulator width
CYCLE_DEPTH, 256, offset_for_ref_frame table entries

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous, active-low reset
tbl_clr  in  1  clear table sum (SPS start)
tbl_wr_en  in  1  table write strobe
tbl_wr_addr  in  log2(CYCLE_DEPTH)  table index
tbl_wr_data  in  POC_W  signed offset_for_ref_frame[i]
num_ref_frames_in_cycle  in  log2(CYCLE_DEPTH)+1  cycle length
poc_type  in  2  pic_order_cnt_type
log2_max_frame_num  in  5  4..FRAME_NUM_W
log2_max_poc_lsb  in  5  4..LSB_W
offset_for_non_ref_pic, offset_for_top_to_bottom_field  in  POC_W  signed
start  in  1  begin one picture
idr, is_ref, mmco5  in  1  current-picture flags
frame_num  in  FRAME_NUM_W
pic_order_cnt_lsb  in  LSB_W
delta_poc_bottom, delta_poc_0, delta_poc_1  in  POC_W  signed
busy  out  1  computation in progress
done  out  1  one-cycle result pulse
top_poc, bot_poc, poc  out  POC_W  signed results; poc = min(top,bot)

Behaviour:
- Reset: all outputs 0, state IDLE, table sum 0, prev state (prevMsb, prevLsb, prevFrameNum, prevFrameNumOffset) 0. Table contents are don't-care.
- Table: tbl_clr zeroes expectedDeltaPerCycle. Each tbl_wr_en writes the entry and adds tbl_wr_data to the sum. Same-cycle clr+wr: sum = data.
- start is accepted only in IDLE; start while busy is ignored. Inputs must be held stable until done. busy is high from the cycle after acceptance through DONE.
- FSM: IDLE→CALC for types 0/2 and for type 1 with absFrameNum==0. Otherwise IDLE→DIV→MUL→ACC→CALC. CALC→DONE→IDLE.
- FrameNumOffset (32b): 0 if idr; else prevFNO + 2^log2_max_frame_num if prevFrameNum > frame_num; else prevFNO.
- Type 0:
  - prevMsb/prevLsb are 0 if idr.
  - Msb = prevMsb + Max if lsb < prevLsb and prevLsb − lsb ≥ Max/2.
  - Msb = prevMsb − Max if lsb > prevLsb and lsb − prevLsb > Max/2.
  - Otherwise Msb = prevMsb.
  - top = Msb + lsb; bot = top + delta_poc_bottom.
- Type 1:
  - absFrameNum = 0 if num_ref_frames_in_cycle==0; else FNO + frame_num, minus 1 if !is_ref and the sum > 0.
  - DIV: 32-cycle restoring divide of (absFrameNum−1) by cycle length → cnt, rem.
  - MUL: 32-cycle shift-add, expected = cnt × sum.
  - ACC: rem+1 cycles, adds table[0..rem] with combinational table read.
  - CALC: if !is_ref, add offset_for_non_ref_pic. top = expected + delta_poc_0; bot = top + offset_for_top_to_bottom_field + delta_poc_1.
- Type 2: temp = 0 if idr, else 2(FNO + frame_num) − (is_ref?0:1); top = bot = temp.
- Latency (accept = cycle 0): done at cycle 2 on the short path; at cycle 67+rem on the type-1 long path. Outputs are registered in DONE and hold until the next DONE.
- Commit in DONE:
  - prevFrameNum ← frame_num; prevFNO ← FNO.
  - Type 0, is_ref only: prevMsb ← Msb, prevLsb ← lsb.
  - If mmco5: prevFNO ← 0, prevFrameNum ← 0, prevMsb ← 0, prevLsb ← top − min(top,bot). Reported outputs are not adjusted.
- All arithmetic is two's-complement at POC_W with wrap; no saturation.
- Reset mid-operation returns to IDLE with no commit; done stays low.
- poc_type==3: treated as type 2.

Test Plan:
1. Type 0, Max=16: ref picture with lsb=14 commits; next lsb=2, delta_poc_bottom=1 → top=18, bot=19, poc=18, done at cycle 2.
2. Type 2, max_frame_num=16: prev frame_num=15, FNO=0; non-ref frame_num=1 → top=bot=33.
3. Type 1: table {2,4,6}, num=3, sum=12; ref frame_num=7, FNO=0, delta_poc_0=0, t2b=1 → top=26, bot=27, done at cycle 67. Non-ref frame_num=8, offset_for_non_ref_pic=−5 → top=21.
4. mmco5 on a type-0 picture with top=20, bot=18 → next picture sees prevMsb=0, prevLsb=2. Outputs stay 20/18.
5. start pulsed during busy → ignored, single done. reset_n low mid-DIV → outputs 0, prev state 0, no done.
6. num_ref_frames_in_cycle=0 with type 1 → expected=0, done at cycle 2, top = delta_poc_0.

Source files
------------

// File: rtl/poc_decoder_multi.sv
// poc_decoder_multi
// Picture-order-count engine for H.264 pic_order_cnt_type 0, 1 and 2 (3 is
// handled as 2). One picture is processed per start/done transaction.
//
// Handshake: start is accepted only while busy is low (IDLE). The picture
// inputs must be held stable from acceptance until done. busy is high from
// the cycle after acceptance through the done cycle. done is a single-cycle
// pulse, and top_poc/bot_poc/poc carry that picture's result from the done
// cycle until the next done.
//
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   tbl_clr, tbl_wr_en,           offset_for_ref_frame table load; tbl_clr
//   tbl_wr_addr, tbl_wr_data      restarts the running cycle sum
//   num_ref_frames_in_cycle       type-1 cycle length (0 = empty cycle)
//   poc_type, log2_max_frame_num, log2_max_poc_lsb,
//   offset_for_non_ref_pic, offset_for_top_to_bottom_field   SPS fields
//   start, idr, is_ref, mmco5, frame_num, pic_order_cnt_lsb,
//   delta_poc_bottom, delta_poc_0, delta_poc_1                per picture
//   busy, done, top_poc, bot_poc, poc                         status/results
module poc_decoder_multi #(
   parameter int FRAME_NUM_W = 16,
   parameter int LSB_W       = 16,
   parameter int POC_W       = 32,
   parameter int CYCLE_DEPTH = 256,
   localparam int AW         = $clog2(CYCLE_DEPTH)
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    tbl_clr,
   input  logic                    tbl_wr_en,
   input  logic [AW-1:0]           tbl_wr_addr,
   input  logic signed [POC_W-1:0] tbl_wr_data,
   input  logic [AW:0]             num_ref_frames_in_cycle,
   input  logic [1:0]              poc_type,
   input  logic [4:0]              log2_max_frame_num,
   input  logic [4:0]              log2_max_poc_lsb,
   input  logic signed [POC_W-1:0] offset_for_non_ref_pic,
   input  logic signed [POC_W-1:0] offset_for_top_to_bottom_field,
   input  logic                    start,
   input  logic                    idr,
   input  logic                    is_ref,
   input  logic                    mmco5,
   input  logic [FRAME_NUM_W-1:0]  frame_num,
   input  logic [LSB_W-1:0]        pic_order_cnt_lsb,
   input  logic signed [POC_W-1:0] delta_poc_bottom,
   input  logic signed [POC_W-1:0] delta_poc_0,
   input  logic signed [POC_W-1:0] delta_poc_1,
   output logic                    busy,
   output logic                    done,
   output logic signed [POC_W-1:0] top_poc,
   output logic signed [POC_W-1:0] bot_poc,
   output logic signed [POC_W-1:0] poc
);

   localparam int SW = $clog2(POC_W);

   typedef enum logic [2:0] {S_IDLE, S_DIV, S_MUL, S_ACC, S_CALC, S_DONE} state_t;
   state_t state_q, state_d;

   // offset_for_ref_frame table and its running sum
   logic signed [POC_W-1:0] tbl [CYCLE_DEPTH];
   logic signed [POC_W-1:0] tbl_sum;

   // previous-picture state
   logic signed [POC_W-1:0] prev_msb, prev_lsb, prev_fno;
   logic [FRAME_NUM_W-1:0]  prev_frame_num;

   // type-1 iterative datapath
   logic [POC_W-1:0]        div_quo, div_rem, div_shift, div_sub, divisor;
   logic signed [POC_W-1:0] mcand, exp_r;
   logic [SW-1:0]           step_r;
   logic [AW-1:0]           acc_idx;
   logic                    last_step, acc_last, long_path;

   // combinational picture arithmetic
   logic signed [POC_W-1:0] fn_ext, lsb_ext, max_fn, max_lsb, half_lsb;
   logic signed [POC_W-1:0] fno_c, abs_sum, abs_c, msb_c, t2_c, non_ref_one;
   logic signed [POC_W-1:0] pm, pl, non_ref_add, top_c, bot_c, poc_c;

   // prev_* only change when leaving DONE, so everything derived from them
   // below stays valid for the whole life of the picture.
   assign fn_ext      = POC_W'(frame_num);
   assign lsb_ext     = POC_W'(pic_order_cnt_lsb);
   assign max_fn      = POC_W'(1) << log2_max_frame_num;
   assign max_lsb     = POC_W'(1) << log2_max_poc_lsb;
   assign half_lsb    = max_lsb >>> 1;
   assign non_ref_one = {{(POC_W-1){1'b0}}, ~is_ref};
   assign fno_c       = idr ? '0 : (prev_frame_num > frame_num) ? prev_fno + max_fn : prev_fno;
   assign abs_sum     = fno_c + fn_ext;
   assign abs_c       = (num_ref_frames_in_cycle == '0) ? '0 :
                        (!is_ref && abs_sum != '0) ? abs_sum - POC_W'(1) : abs_sum;
   assign t2_c        = idr ? '0 : (abs_sum <<< 1) - non_ref_one;
   assign non_ref_add = is_ref ? '0 : offset_for_non_ref_pic;

   assign divisor   = POC_W'(num_ref_frames_in_cycle);
   assign div_shift = {div_rem[POC_W-2:0], div_quo[POC_W-1]};
   assign div_sub   = div_shift - divisor;
   assign last_step = (step_r == SW'(POC_W-1));
   assign acc_last  = (POC_W'(acc_idx) == div_rem);
   assign long_path = (poc_type == 2'd1) && (abs_c != '0);

   // Type-0 MSB wrap detection against the previous reference picture
   always_comb begin
      pm    = idr ? '0 : prev_msb;
      pl    = idr ? '0 : prev_lsb;
      msb_c = pm;
      if (lsb_ext < pl && (pl - lsb_ext) >= half_lsb)
         msb_c = pm + max_lsb;
      else if (lsb_ext > pl && (lsb_ext - pl) > half_lsb)
         msb_c = pm - max_lsb;
   end

   always_comb begin
      top_c = '0;
      bot_c = '0;
      if (poc_type == 2'd0) begin
         top_c = msb_c + lsb_ext;
         bot_c = top_c + delta_poc_bottom;
      end else if (poc_type == 2'd1) begin
         top_c = exp_r + non_ref_add + delta_poc_0;
         bot_c = top_c + offset_for_top_to_bottom_field + delta_poc_1;
      end else begin
         top_c = t2_c;
         bot_c = t2_c;
      end
      poc_c = (top_c < bot_c) ? top_c : bot_c;
   end

   // FSM
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = long_path ? S_DIV : S_CALC;
         S_DIV:   if (last_step) state_d = S_MUL;
         S_MUL:   if (last_step) state_d = S_ACC;
         S_ACC:   if (acc_last) state_d = S_CALC;
         S_CALC:  state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign busy = (state_q != S_IDLE);
   assign done = (state_q == S_DONE);

   // Table storage: contents need no reset
   always_ff @(posedge clk) begin
      if (tbl_wr_en) tbl[tbl_wr_addr] <= tbl_wr_data;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)      tbl_sum <= '0;
      else if (tbl_clr)  tbl_sum <= tbl_wr_en ? tbl_wr_data : '0;
      else if (tbl_wr_en) tbl_sum <= tbl_sum + tbl_wr_data;
   end

   // Datapath, results and previous-picture state
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_quo <= '0; div_rem <= '0; step_r <= '0; acc_idx <= '0;
         mcand <= '0; exp_r <= '0;
         top_poc <= '0; bot_poc <= '0; poc <= '0;
         prev_msb <= '0; prev_lsb <= '0; prev_fno <= '0; prev_frame_num <= '0;
      end else begin
         case (state_q)
            S_IDLE: if (start) begin
               div_quo <= abs_c - POC_W'(1);
               div_rem <= '0;
               step_r  <= '0;
               acc_idx <= '0;
               mcand   <= tbl_sum;
               exp_r   <= '0;
            end
            // restoring divide: quotient bits replace dividend bits in div_quo
            S_DIV: begin
               if (div_shift >= divisor) begin
                  div_rem <= div_sub;
                  div_quo <= {div_quo[POC_W-2:0], 1'b1};
               end else begin
                  div_rem <= div_shift;
                  div_quo <= {div_quo[POC_W-2:0], 1'b0};
               end
               step_r <= last_step ? '0 : step_r + SW'(1);
            end
            // shift-add multiply: quotient x cycle sum
            S_MUL: begin
               if (div_quo[0]) exp_r <= exp_r + mcand;
               mcand   <= mcand <<< 1;
               div_quo <= div_quo >> 1;
               step_r  <= last_step ? '0 : step_r + SW'(1);
            end
            // partial cycle: table[0..rem]
            S_ACC: begin
               exp_r   <= exp_r + tbl[acc_idx];
               acc_idx <= acc_idx + AW'(1);
            end
            S_CALC: begin
               top_poc <= top_c;
               bot_poc <= bot_c;
               poc     <= poc_c;
            end
            S_DONE: begin
               if (mmco5) begin
                  prev_frame_num <= '0;
                  prev_fno       <= '0;
                  prev_msb       <= '0;
                  prev_lsb       <= top_poc - poc;
               end else begin
                  prev_frame_num <= frame_num;
                  prev_fno       <= fno_c;
                  if (poc_type == 2'd0 && is_ref) begin
                     prev_msb <= msb_c;
                     prev_lsb <= lsb_ext;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_poc_decoder_multi.sv
// tb_poc_decoder_multi
// Directed vector table for the documented corner cases, hand sequences for
// busy-start and mid-operation reset, then randomized pictures compared
// against a reference model that computes POC values arithmetically.
module tb_poc_decoder_multi;

   localparam int POC_W = 32;
   localparam int FN_W  = 16;
   localparam int LSB_W = 16;
   localparam int DEPTH = 256;
   localparam int AW    = 8;

   logic                    clk = 1'b0;
   logic                    reset_n = 1'b0;
   logic                    tbl_clr = 1'b0;
   logic                    tbl_wr_en = 1'b0;
   logic [AW-1:0]           tbl_wr_addr = '0;
   logic signed [POC_W-1:0] tbl_wr_data = '0;
   logic [AW:0]             num_ref_frames_in_cycle = '0;
   logic [1:0]              poc_type = '0;
   logic [4:0]              log2_max_frame_num = 5'd4;
   logic [4:0]              log2_max_poc_lsb = 5'd4;
   logic signed [POC_W-1:0] offset_for_non_ref_pic = '0;
   logic signed [POC_W-1:0] offset_for_top_to_bottom_field = '0;
   logic                    start = 1'b0;
   logic                    idr = 1'b0;
   logic                    is_ref = 1'b0;
   logic                    mmco5 = 1'b0;
   logic [FN_W-1:0]         frame_num = '0;
   logic [LSB_W-1:0]        pic_order_cnt_lsb = '0;
   logic signed [POC_W-1:0] delta_poc_bottom = '0;
   logic signed [POC_W-1:0] delta_poc_0 = '0;
   logic signed [POC_W-1:0] delta_poc_1 = '0;
   logic                    busy, done;
   logic signed [POC_W-1:0] top_poc, bot_poc, poc;

   poc_decoder_multi dut (
      .clk(clk), .reset_n(reset_n),
      .tbl_clr(tbl_clr), .tbl_wr_en(tbl_wr_en), .tbl_wr_addr(tbl_wr_addr),
      .tbl_wr_data(tbl_wr_data), .num_ref_frames_in_cycle(num_ref_frames_in_cycle),
      .poc_type(poc_type), .log2_max_frame_num(log2_max_frame_num),
      .log2_max_poc_lsb(log2_max_poc_lsb),
      .offset_for_non_ref_pic(offset_for_non_ref_pic),
      .offset_for_top_to_bottom_field(offset_for_top_to_bottom_field),
      .start(start), .idr(idr), .is_ref(is_ref), .mmco5(mmco5),
      .frame_num(frame_num), .pic_order_cnt_lsb(pic_order_cnt_lsb),
      .delta_poc_bottom(delta_poc_bottom), .delta_poc_0(delta_poc_0),
      .delta_poc_1(delta_poc_1),
      .busy(busy), .done(done), .top_poc(top_poc), .bot_poc(bot_poc), .poc(poc)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   int checks = 0;
   int failures = 0;
   logic [POC_W-1:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, $signed(act), $signed(exp));
      end
   endtask

   typedef struct {
      int ptype, l2fn, l2lsb, idr, is_ref, mmco5, fn, lsb;
      int dpb, dp0, dp1, onr, t2b, ncyc;
      int exp_top, exp_bot, exp_lat;
   } vec_t;

   // ---------------- reference model ----------------
   int m_prev_msb = 0, m_prev_lsb = 0, m_prev_fno = 0, m_prev_fn = 0;
   int m_tbl[DEPTH];
   int m_sum = 0;

   task automatic model_pic(input vec_t v, output int top, output int bot, output int lat);
      int fno, t, msb, pm, pl, maxl, absf, cnt, rem, expected;
      fno = v.idr ? 0 : ((m_prev_fn > v.fn) ? m_prev_fno + (1 << v.l2fn) : m_prev_fno);
      t = (v.ptype == 3) ? 2 : v.ptype;
      lat = 2;
      msb = 0;
      if (t == 0) begin
         pm = v.idr ? 0 : m_prev_msb;
         pl = v.idr ? 0 : m_prev_lsb;
         maxl = 1 << v.l2lsb;
         if (v.lsb < pl && pl - v.lsb >= maxl / 2) msb = pm + maxl;
         else if (v.lsb > pl && v.lsb - pl > maxl / 2) msb = pm - maxl;
         else msb = pm;
         top = msb + v.lsb;
         bot = top + v.dpb;
      end else if (t == 1) begin
         absf = (v.ncyc == 0) ? 0 : fno + v.fn;
         if (v.ncyc != 0 && v.is_ref == 0 && absf > 0) absf = absf - 1;
         expected = 0;
         if (absf > 0) begin
            cnt = (absf - 1) / v.ncyc;
            rem = (absf - 1) % v.ncyc;
            expected = cnt * m_sum;
            for (int i = 0; i <= rem; i++) expected += m_tbl[i];
            lat = 67 + rem;
         end
         if (v.is_ref == 0) expected += v.onr;
         top = expected + v.dp0;
         bot = top + v.t2b + v.dp1;
      end else begin
         top = v.idr ? 0 : 2 * (fno + v.fn) - (v.is_ref ? 0 : 1);
         bot = top;
      end
      if (v.mmco5 != 0) begin
         m_prev_fn = 0;
         m_prev_fno = 0;
         m_prev_msb = 0;
         m_prev_lsb = top - ((top < bot) ? top : bot);
      end else begin
         m_prev_fn = v.fn;
         m_prev_fno = fno;
         if (t == 0 && v.is_ref != 0) begin
            m_prev_msb = msb;
            m_prev_lsb = v.lsb;
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tbl_write(input int addr, input int data, input bit clr);
      @(negedge clk);
      tbl_wr_en = 1'b1;
      tbl_clr = clr;
      tbl_wr_addr = AW'(addr);
      tbl_wr_data = data;
      @(posedge clk);
      #1;
      tbl_wr_en = 1'b0;
      tbl_clr = 1'b0;
      m_tbl[addr] = data;
      m_sum = clr ? data : m_sum + data;
   endtask

   task automatic apply(input vec_t v);
      poc_type = 2'(v.ptype);
      log2_max_frame_num = 5'(v.l2fn);
      log2_max_poc_lsb = 5'(v.l2lsb);
      idr = v.idr[0];
      is_ref = v.is_ref[0];
      mmco5 = v.mmco5[0];
      frame_num = FN_W'(v.fn);
      pic_order_cnt_lsb = LSB_W'(v.lsb);
      delta_poc_bottom = v.dpb;
      delta_poc_0 = v.dp0;
      delta_poc_1 = v.dp1;
      offset_for_non_ref_pic = v.onr;
      offset_for_top_to_bottom_field = v.t2b;
      num_ref_frames_in_cycle = (AW+1)'(v.ncyc);
   endtask

   task automatic run_pic(input vec_t v, output logic [31:0] t, output logic [31:0] b,
                          output logic [31:0] p, output int lat);
      @(negedge clk);
      apply(v);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      lat = -1;
      for (int c = 1; c < 200; c++) begin
         @(negedge clk);
         if (done) begin
            lat = c;
            break;
         end
      end
      t = top_poc;
      b = bot_poc;
      p = poc;
      @(posedge clk);
      #1;
      check("done_width", {31'd0, done}, 32'd0);
   endtask

   function automatic vec_t rand_vec(input int n);
      vec_t v;
      v.ptype = int'($urandom_range(3));
      v.l2fn = int'($urandom_range(8, 4));
      v.l2lsb = int'($urandom_range(8, 4));
      v.idr = ($urandom_range(7) == 0) ? 1 : 0;
      v.is_ref = int'($urandom_range(1));
      v.mmco5 = ($urandom_range(9) == 0) ? 1 : 0;
      v.fn = int'($urandom_range((1 << v.l2fn) - 1));
      v.lsb = int'($urandom_range((1 << v.l2lsb) - 1));
      v.dpb = int'($urandom_range(20)) - 10;
      v.dp0 = int'($urandom_range(20)) - 10;
      v.dp1 = int'($urandom_range(20)) - 10;
      v.onr = int'($urandom_range(20)) - 10;
      v.t2b = int'($urandom_range(20)) - 10;
      v.ncyc = ($urandom_range(9) == 0) ? 0 : n;
      v.exp_top = 0;
      v.exp_bot = 0;
      v.exp_lat = 0;
      return v;
   endfunction

   // ---------------- test sequence ----------------
   vec_t vecs[12];

   initial begin
      logic [31:0] t, b, p;
      int lat, mt, mb, ml, dn, first, n;
      vec_t v;

      //          type l2fn l2lsb idr ref mm5 fn lsb dpb dp0 dp1 onr t2b ncyc  top bot lat
      vecs[0]  = '{0, 4, 4, 1, 1, 0,  0,  6,  0, 0, 0,  0, 0, 3,    6,  6,  2};
      vecs[1]  = '{0, 4, 4, 0, 1, 0,  1, 14,  0, 0, 0,  0, 0, 3,   14, 14,  2};
      vecs[2]  = '{0, 4, 4, 0, 1, 0,  2,  2,  1, 0, 0,  0, 0, 3,   18, 19,  2};
      vecs[3]  = '{0, 4, 4, 0, 1, 1,  3,  4, -2, 0, 0,  0, 0, 3,   20, 18,  2};
      vecs[4]  = '{0, 4, 4, 0, 1, 0,  1, 12,  0, 0, 0,  0, 0, 3,   -4, -4,  2};
      vecs[5]  = '{2, 4, 4, 0, 1, 0, 15,  0,  0, 0, 0,  0, 0, 3,   30, 30,  2};
      vecs[6]  = '{2, 4, 4, 0, 0, 0,  1,  0,  0, 0, 0,  0, 0, 3,   33, 33,  2};
      vecs[7]  = '{1, 4, 4, 1, 1, 0,  7,  0,  0, 0, 0,  0, 1, 3,   26, 27, 67};
      vecs[8]  = '{1, 4, 4, 0, 0, 0,  8,  0,  0, 0, 0, -5, 1, 3,   21, 22, 67};
      vecs[9]  = '{1, 4, 4, 0, 1, 0,  9,  0,  0, 5, 2,  0, 1, 0,    5,  8,  2};
      vecs[10] = '{1, 4, 4, 0, 1, 0, 11,  0,  0, 0, 0,  0, 0, 3,   42, 42, 68};
      vecs[11] = '{3, 4, 4, 0, 1, 0, 12,  0,  0, 0, 0,  0, 0, 3,   24, 24,  2};

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_top", top_poc, 32'd0);
      check("rst_bot", bot_poc, 32'd0);
      check("rst_poc", poc, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      reset_n = 1'b1;

      // table {2,4,6}, sum 12
      tbl_write(0, 2, 1'b1);
      tbl_write(1, 4, 1'b0);
      tbl_write(2, 6, 1'b0);

      // directed vectors
      for (int i = 0; i < 12; i++) begin
         model_pic(vecs[i], mt, mb, ml);
         run_pic(vecs[i], t, b, p, lat);
         check($sformatf("vec%0d_top", i), t, vecs[i].exp_top);
         check($sformatf("vec%0d_bot", i), b, vecs[i].exp_bot);
         check($sformatf("vec%0d_poc", i), p,
               (vecs[i].exp_top < vecs[i].exp_bot) ? vecs[i].exp_top : vecs[i].exp_bot);
         check($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
      end

      // start pulsed while busy: one done, expected result 4*12+2 = 50
      v = '{1, 4, 4, 0, 1, 0, 13, 0, 0, 0, 0, 0, 0, 3, 50, 50, 67};
      model_pic(v, mt, mb, ml);
      @(negedge clk);
      apply(v);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      dn = 0;
      first = -1;
      t = '0;
      for (int c = 1; c < 150; c++) begin
         @(negedge clk);
         if (c == 5) begin
            check("busy_mid", {31'd0, busy}, 32'd1);
            start = 1'b1;
         end
         if (c == 6) start = 1'b0;
         if (done) begin
            dn++;
            if (first < 0) begin
               first = c;
               t = top_poc;
            end
         end
      end
      check("busy_start_done_count", dn, 32'd1);
      check("busy_start_lat", first, v.exp_lat);
      check("busy_start_top", t, v.exp_top);

      // reset during DIV: no done, outputs and previous state cleared
      v = '{1, 4, 4, 0, 1, 0, 14, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0};
      @(negedge clk);
      apply(v);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (10) @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("midrst_top", top_poc, 32'd0);
      check("midrst_bot", bot_poc, 32'd0);
      check("midrst_poc", poc, 32'd0);
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_done", {31'd0, done}, 32'd0);
      m_prev_msb = 0; m_prev_lsb = 0; m_prev_fno = 0; m_prev_fn = 0; m_sum = 0;
      @(negedge clk);
      reset_n = 1'b1;
      dn = 0;
      for (int c = 0; c < 80; c++) begin
         @(negedge clk);
         if (done) dn++;
      end
      check("midrst_no_done", dn, 32'd0);
      // prev frame_num must be 0 again: FNO stays 0, temp = 2*3
      v = '{2, 4, 4, 0, 1, 0, 3, 0, 0, 0, 0, 0, 0, 3, 6, 6, 2};
      model_pic(v, mt, mb, ml);
      run_pic(v, t, b, p, lat);
      check("postrst_top", t, v.exp_top);
      check("postrst_lat", lat, v.exp_lat);

      // randomized pictures against the model, two table loads
      for (int round = 0; round < 2; round++) begin
         n = int'($urandom_range(8, 1));
         tbl_write(0, int'($urandom_range(40)) - 20, 1'b1);
         for (int i = 1; i < n; i++) tbl_write(i, int'($urandom_range(40)) - 20, 1'b0);
         tbl_write(n, int'($urandom_range(40)) - 20, 1'b0);
         for (int k = 0; k < 25; k++) begin
            v = rand_vec(n);
            model_pic(v, mt, mb, ml);
            exp_q.push_back(mt);
            exp_q.push_back(mb);
            exp_q.push_back((mt < mb) ? mt : mb);
            exp_q.push_back(ml);
            run_pic(v, t, b, p, lat);
            check($sformatf("rnd%0d_%0d_top", round, k), t, exp_q.pop_front());
            check($sformatf("rnd%0d_%0d_bot", round, k), b, exp_q.pop_front());
            check($sformatf("rnd%0d_%0d_poc", round, k), p, exp_q.pop_front());
            check($sformatf("rnd%0d_%0d_lat", round, k), lat, exp_q.pop_front());
         end
      end

      // ---------------- report ----------------
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
